// File: rtl/net_iface_if.sv
// rtl/net_iface_if.sv - request, injection, ejection and response signals of net_iface
//
// Signals (slave = net_iface side, master = cache/router/bench side):
//   req_valid, req_dest[3:0], req_data[4:0]  cache request into the injection FIFO
//   req_ready                                 FIFO can accept a request (~full)
//   inj_free                                  router has a free local input slot
//   inj_flit[9:0]                             flit to router local input, bit 9 = valid
//   starve                                    head flit blocked STARVE_LIMIT cycles
//   ej_flit[9:0]                              flit from router local output
//   rsp_valid, rsp_data[4:0]                  delivered payload, one-cycle pulse
//   misroute                                  sticky wrong-destination flag
//   inj_count, ej_count [15:0]                only when NET_IFACE_STATS_EN is defined
interface net_iface_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_dest;
   logic [4:0] req_data;
   logic       inj_free;
   logic [9:0] inj_flit;
   logic       starve;
   logic [9:0] ej_flit;
   logic       rsp_valid;
   logic [4:0] rsp_data;
   logic       misroute;
`ifdef NET_IFACE_STATS_EN
   logic [15:0] inj_count;
   logic [15:0] ej_count;

   modport slave (
      input  req_valid, req_dest, req_data, inj_free, ej_flit,
      output req_ready, inj_flit, starve, rsp_valid, rsp_data, misroute,
      output inj_count, ej_count
   );
   modport master (
      output req_valid, req_dest, req_data, inj_free, ej_flit,
      input  req_ready, inj_flit, starve, rsp_valid, rsp_data, misroute,
      input  inj_count, ej_count
   );
`else
   modport slave (
      input  req_valid, req_dest, req_data, inj_free, ej_flit,
      output req_ready, inj_flit, starve, rsp_valid, rsp_data, misroute
   );
   modport master (
      output req_valid, req_dest, req_data, inj_free, ej_flit,
      input  req_ready, inj_flit, starve, rsp_valid, rsp_data, misroute
   );
`endif
endinterface

// File: rtl/net_iface.sv
// rtl/net_iface.sv - local injection/ejection interface between cache and bufferless router
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   net_iface_if.slave (request, injection, ejection, response signals)
// Optional feature macro: NET_IFACE_STATS_EN adds bus.inj_count / bus.ej_count.
module net_iface #(
   parameter logic [3:0] NODE_ID      = 4'd0,
   parameter int         DEPTH        = 4,
   parameter int         STARVE_LIMIT = 15
) (
   input logic         clk,
   input logic         rst,
   net_iface_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [7:0]    SLIMIT   = 8'(STARVE_LIMIT);

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    starve_cnt;
   logic [7:0]    starve_cnt_nxt;

   logic full, empty, push, pop, blocked;
   logic ej_hit, ej_miss;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // No push-through-pop: a full FIFO refuses even if it drains this cycle.
   assign push    = bus.req_valid & ~full;
   assign pop     = ~empty & bus.inj_free;
   assign blocked = ~empty & ~bus.inj_free;

   assign bus.req_ready = ~full;

   // Any cycle that is not blocked either pops or finds the FIFO empty,
   // both of which clear the counter.
   always_comb begin
      starve_cnt_nxt = '0;
      if (blocked)
         starve_cnt_nxt = (starve_cnt == SLIMIT) ? starve_cnt : starve_cnt + 8'd1;
   end

   assign ej_hit  = bus.ej_flit[9] & (bus.ej_flit[8:5] == NODE_ID);
   assign ej_miss = bus.ej_flit[9] & (bus.ej_flit[8:5] != NODE_ID);

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.req_dest, bus.req_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         starve_cnt   <= '0;
         bus.starve   <= 1'b0;
         bus.inj_flit <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         starve_cnt   <= starve_cnt_nxt;
         // Decode the next value so starve tracks the counter without an extra cycle.
         bus.starve   <= (starve_cnt_nxt == SLIMIT);
         bus.inj_flit <= pop ? {1'b1, mem[rd_ptr]} : 10'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.misroute  <= 1'b0;
      end else begin
         bus.rsp_valid <= ej_hit;
         if (ej_hit)
            bus.rsp_data <= bus.ej_flit[4:0];
         bus.misroute  <= bus.misroute | ej_miss;
      end
   end

`ifdef NET_IFACE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.inj_count <= '0;
         bus.ej_count  <= '0;
      end else begin
         if (pop)
            bus.inj_count <= bus.inj_count + 16'd1;
         if (bus.rsp_valid)
            bus.ej_count <= bus.ej_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_net_iface.sv
// tb/tb_net_iface.sv - scoreboard bench for net_iface
module tb_net_iface;

   localparam int         DEPTH = 4;
   localparam int         LIMIT = 15;
   localparam logic [3:0] MYID  = 4'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   net_iface_if ifc ();

   net_iface #(.NODE_ID(MYID), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   typedef struct {
      logic [9:0] v;
      int         due;
   } exp_t;

   exp_t       exp_inj[$];
   exp_t       exp_rsp[$];
   logic [8:0] mq[$];
   int         mst   = 0;
   logic       mmis  = 1'b0;
   logic [4:0] mlast = '0;
   int         minj  = 0;
   int         mej   = 0;
   int         cyc   = 0;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   // Drive one cycle, advance the reference model across the edge, check scalars.
   task automatic step(input logic rv, input logic [3:0] d, input logic [4:0] p,
                       input logic fr, input logic [9:0] ej, input logic r);
      bit do_push, do_pop;
      exp_t e;
      ifc.req_valid = rv;
      ifc.req_dest  = d;
      ifc.req_data  = p;
      ifc.inj_free  = fr;
      ifc.ej_flit   = ej;
      rst           = r;
      @(posedge clk);
      cyc++;
      if (r) begin
         mq.delete();
         mst = 0; mmis = 1'b0; mlast = '0; minj = 0; mej = 0;
      end else begin
         do_pop  = (mq.size() > 0) && fr;
         do_push = rv && (mq.size() < DEPTH);
         if ((mq.size() > 0) && !fr) mst = (mst < LIMIT) ? mst + 1 : LIMIT;
         else mst = 0;
         if (do_pop) begin
            e.v = {1'b1, mq.pop_front()};
            e.due = cyc;
            exp_inj.push_back(e);
            minj = (minj + 1) % 65536;
         end
         if (do_push) mq.push_back({d, p});
         if (ej[9] && ej[8:5] == MYID) begin
            e.v = {5'b0, ej[4:0]};
            e.due = cyc;
            exp_rsp.push_back(e);
            mlast = ej[4:0];
         end
         if (ej[9] && ej[8:5] != MYID) mmis = 1'b1;
      end
      @(negedge clk);
      chk("req_ready", 32'(ifc.req_ready), 32'(mq.size() < DEPTH));
      chk("starve", 32'(ifc.starve), 32'(mst == LIMIT));
      chk("misroute", 32'(ifc.misroute), 32'(mmis));
      chk("rsp_data", 32'(ifc.rsp_data), 32'(mlast));
`ifdef NET_IFACE_STATS_EN
      chk("inj_count", 32'(ifc.inj_count), 32'(minj));
      chk("ej_count", 32'(ifc.ej_count), 32'(mej));
      if (!r && ifc.rsp_valid === 1'b1) mej = (mej + 1) % 65536;
`endif
   endtask

   task automatic idle(input logic fr, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 5'd0, fr, 10'd0, 1'b0);
   endtask

   // Monitor: consume expected flits/responses only when the DUT presents them.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         while (exp_inj.size() > 0 && exp_inj[0].due < cyc) begin
            chk("inj_missing", 32'(0), 32'(exp_inj[0].v));
            void'(exp_inj.pop_front());
         end
         if (ifc.inj_flit !== 10'd0) begin
            if (exp_inj.size() > 0 && exp_inj[0].due == cyc)
               chk("inj_flit", 32'(ifc.inj_flit), 32'(exp_inj.pop_front().v));
            else
               chk("inj_unexpected", 32'(ifc.inj_flit), 32'(0));
         end
         while (exp_rsp.size() > 0 && exp_rsp[0].due < cyc) begin
            chk("rsp_missing", 32'(0), 32'(1));
            void'(exp_rsp.pop_front());
         end
         if (ifc.rsp_valid === 1'b1) begin
            if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc)
               chk("rsp_payload", 32'(ifc.rsp_data), 32'(exp_rsp.pop_front().v));
            else
               chk("rsp_unexpected", 32'(1), 32'(0));
         end
      end
   end

   initial begin
      logic [9:0] ej;
      // reset
      step(1'b0, 4'd0, 5'd0, 1'b0, 10'd0, 1'b1);
      step(1'b0, 4'd0, 5'd0, 1'b0, 10'd0, 1'b1);
      chk("reset_inj_flit", 32'(ifc.inj_flit), 32'(0));
      chk("reset_rsp_valid", 32'(ifc.rsp_valid), 32'(0));
      // single request through an idle router
      step(1'b1, 4'd5, 5'h0A, 1'b1, 10'd0, 1'b0);
      step(1'b0, 4'd0, 5'd0, 1'b1, 10'd0, 1'b0);
      chk("first_flit", 32'(ifc.inj_flit), 32'(10'b1_0101_01010));
      idle(1'b1, 2);
      // fill while blocked, one refused, then drain in order
      for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 5'(i + 16), 1'b0, 10'd0, 1'b0);
      idle(1'b1, 6);
      // starvation of a single queued flit
      step(1'b1, 4'd9, 5'h11, 1'b0, 10'd0, 1'b0);
      idle(1'b0, 20);
      idle(1'b1, 3);
      // ejection: hit, invalid, misroute
      step(1'b0, 4'd0, 5'd0, 1'b0, 10'b1_0011_10101, 1'b0);
      step(1'b0, 4'd0, 5'd0, 1'b0, 10'b0_0011_11111, 1'b0);
      step(1'b0, 4'd0, 5'd0, 1'b0, 10'b1_0111_00001, 1'b0);
      idle(1'b0, 3);
      // reset with flits queued
      for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 6), 5'(i), 1'b0, 10'd0, 1'b0);
      step(1'b0, 4'd0, 5'd0, 1'b0, 10'd0, 1'b1);
      chk("rst_inj_flit", 32'(ifc.inj_flit), 32'(0));
      idle(1'b1, 4);
      step(1'b1, 4'd1, 5'd1, 1'b1, 10'd0, 1'b0);
      step(1'b1, 4'd2, 5'd2, 1'b1, 10'd0, 1'b0);
      idle(1'b1, 3);
      // randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         ej = 10'($urandom);
         if ($urandom_range(0, 3) != 0) ej[8:5] = MYID;
         if ($urandom_range(0, 20) != 0 && ej[8:5] != MYID) ej[9] = 1'b0;
         step(1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom),
              ($urandom_range(0, 9) < 4), ej, ($urandom_range(0, 299) == 0));
      end
      idle(1'b1, 8);
      chk("inj_drained", 32'(exp_inj.size()), 32'(0));
      chk("rsp_drained", 32'(exp_rsp.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/net_iface.md
Name: net_iface

Overview:
Local network interface: the other end of the router's local injection (lin) and ejection (lout) ports.
- Injection side: accepts cache-miss requests, queues them in a small FIFO, and drives 10-bit flits into the router's local input only when the router reports a free input slot. The router is bufferless and cannot take a flit every cycle.
- Ejection side: receives flits ejected by the router, checks the destination and delivers the payload to the cache side.
- Flit format, shared both directions: [9] valid, [8:5] destination node id, [4:0] payload.

Parameters:
NODE_ID, 0, this node's 4-bit id; ejected flits are checked against it.
DEPTH, 4, injection FIFO entries; power of two, >= 2.
STARVE_LIMIT, 15, blocked-cycle count at which starve asserts; 1..255.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  cache request present.
req_ready  out  1  request accepted this cycle when high with req_valid.
req_dest  in  4  request destination node id.
req_data  in  5  request payload.
inj_free  in  1  router has a free input slot this cycle.
inj_flit  out  10  flit to router local input; bit 9 = valid.
starve  out  1  head flit blocked for STARVE_LIMIT consecutive cycles.
ej_flit  in  10  flit from router local output (lout).
rsp_valid  out  1  one-cycle pulse: payload delivered.
rsp_data  out  5  delivered payload.
misroute  out  1  sticky: a valid flit with dest != NODE_ID was ejected.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: FIFO empty, req_ready=1 (from the following cycle), inj_flit=0, starve=0, starve counter=0, rsp_valid=0, rsp_data=0, misroute=0.
- FIFO width is 9 bits ({dest,payload}); count is 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- req_ready is combinational: ~full.
- Push: req_valid & req_ready at a rising edge writes {req_dest, req_data}.
- Full: req_ready=0 even if a pop occurs in the same cycle. There is no push-through-pop when full.
- Pop/inject: at each edge, inj_flit <= {1'b1, head} and pop if (~empty & inj_free); otherwise inj_flit <= 10'b0. inj_flit is valid for exactly one cycle per flit.
- No empty bypass: a flit pushed at edge E0 appears on inj_flit no earlier than edge E1, provided inj_free=1 in the cycle between E0 and E1.
- Simultaneous push and pop when not full: both occur; count is unchanged.
- FIFO order is strict; the head never changes while blocked.
- Starve counter:
  - Increments at each edge where ~empty & ~inj_free.
  - Clears to 0 on any pop or when empty.
  - Saturates at STARVE_LIMIT.
  - starve = (counter == STARVE_LIMIT), registered decode, low again in the cycle after a pop.
- Ejection (1-cycle latency), at each edge:
  - rsp_valid <= ej_flit[9] & (ej_flit[8:5]==NODE_ID).
  - rsp_data <= ej_flit[4:0] when that condition holds; otherwise rsp_data is held.
  - misroute <= misroute | (ej_flit[9] & ej_flit[8:5]!=NODE_ID); only rst clears it.
  - Ejection is never back-pressured; every valid ejected flit is consumed.
- Reset mid-operation: queued flits are discarded, the in-flight inj_flit is dropped (0 after the reset edge), and counters clear. rst has priority over all pushes and pops.

Optional Feature:
NET_IFACE_STATS_EN.
- Defined: adds outputs inj_count[15:0] and ej_count[15:0].
  - inj_count increments on each inject (pop); ej_count increments on each rsp_valid.
  - Both wrap 16'hFFFF -> 0 and reset to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, NODE_ID=3; push dest=5 data=0x0A with inj_free=1 -> inj_flit=10'b1_0101_01010 one cycle after the push edge, then 0; req_ready stays 1.
- inj_free=0; push 4 flits (dest 1..4) -> req_ready=0 after the 4th; a 5th req_valid is not accepted. Raise inj_free -> flits exit in order 1,2,3,4 on consecutive cycles; req_ready returns to 1 after the first pop.
- One flit queued, inj_free=0 for 20 cycles -> starve goes high 15 blocked cycles after the push and stays high; inj_free=1 -> flit injected, starve=0 the next cycle.
- ej_flit=10'b1_0011_10101 with NODE_ID=3 -> rsp_valid=1, rsp_data=0x15 for one cycle. ej_flit=10'b0_0011_11111 -> rsp_valid=0.
- ej_flit=10'b1_0111_00001 with NODE_ID=3 -> rsp_valid=0, misroute=1 and stays 1 until rst.
- 3 flits queued, inj_free=0; assert rst for one cycle -> inj_flit=0, req_ready=1, starve=0, no flit emitted after inj_free=1. With NET_IFACE_STATS_EN, inj_count=0 after reset, then 2 after two injections.
